// File: rtl/pipelined_adder.sv
// Segmented, carry-pipelined adder/subtractor.
// An input register is followed by one register stage per carry segment.
// Each stage adds one segment and passes the carry to the next stage.
// Operand bits not yet added ride along with the sum bits already produced,
// so every segment of one operation leaves the pipeline on the same edge.
module pipelined_adder #(
  parameter int ADDER_WIDTH = 116,
  parameter int SEG_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   in_valid,
  input  logic                   sub,
  input  logic                   cin,
  input  logic [ADDER_WIDTH-1:0] a,
  input  logic [ADDER_WIDTH-1:0] b,
  output logic                   out_valid,
  output logic [ADDER_WIDTH:0]   sum,
  output logic                   ovf
);

  localparam int NSEG  = (ADDER_WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
  localparam int TOP_W = ADDER_WIDTH - (NSEG - 1) * SEG_WIDTH;

  // Input register
  logic [ADDER_WIDTH-1:0] a0_q;
  logic [ADDER_WIDTH-1:0] b0_q;
  logic                   sub0_q;
  logic                   cin0_q;
  logic                   v0_q;

  // Operand conditioning: subtraction is a + ~b + 1
  logic [ADDER_WIDTH-1:0] beff0;
  logic                   c0;

  // Output register
  logic [ADDER_WIDTH:0]   sum_q;
  logic                   ovf_q;
  logic                   out_valid_q;

  // Capture operands and mode; everything freezes while ce is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_q   <= '0;
      b0_q   <= '0;
      sub0_q <= 1'b0;
      cin0_q <= 1'b0;
      v0_q   <= 1'b0;
    end else if (ce) begin
      a0_q   <= a;
      b0_q   <= b;
      sub0_q <= sub;
      cin0_q <= cin;
      v0_q   <= in_valid;
    end
  end

  assign beff0 = sub0_q ? ~b0_q : b0_q;
  assign c0    = sub0_q ? 1'b1 : cin0_q;

  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : stg
      // LO: first bit of this stage's segment; SW: its width;
      // RW: width of the conditioned-B bits still to be consumed.
      localparam int LO = gi * SEG_WIDTH;
      localparam int SW = (gi == NSEG - 1) ? TOP_W : SEG_WIDTH;
      localparam int RW = ADDER_WIDTH - LO;

      // as_src: low LO bits are finished sum bits, the rest are still A.
      logic [ADDER_WIDTH-1:0] as_src;
      logic [RW-1:0]          b_src;
      logic                   c_src;
      logic                   v_src;
      logic [SW:0]            seg_sum;
      logic [ADDER_WIDTH-1:0] as_d;

      if (gi == 0) begin : g_first
        assign as_src = a0_q;
        assign b_src  = beff0;
        assign c_src  = c0;
        assign v_src  = v0_q;
      end else begin : g_next
        assign as_src = stg[gi-1].g_mid.as_q;
        assign b_src  = stg[gi-1].g_mid.b_q;
        assign c_src  = stg[gi-1].g_mid.c_q;
        assign v_src  = stg[gi-1].g_mid.v_q;
      end

      assign seg_sum = {1'b0, as_src[LO +: SW]} + {1'b0, b_src[SW-1:0]}
                     + {{SW{1'b0}}, c_src};

      // Overwrite this segment's A bits with its freshly computed sum bits
      always_comb begin
        as_d = as_src;
        as_d[LO +: SW] = seg_sum[SW-1:0];
      end

      if (gi < NSEG - 1) begin : g_mid
        logic [ADDER_WIDTH-1:0] as_q;
        logic [RW-SW-1:0]       b_q;
        logic                   c_q;
        logic                   v_q;

        // Register partial sum, carry, remaining B bits and valid flag
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            as_q <= '0;
            b_q  <= '0;
            c_q  <= 1'b0;
            v_q  <= 1'b0;
          end else if (ce) begin
            as_q <= as_d;
            b_q  <= b_src[RW-1:SW];
            c_q  <= seg_sum[SW];
            v_q  <= v_src;
          end
        end
      end else begin : g_last
        logic ovf_d;

        // The MSB of A is still present here because the top segment is
        // the last one consumed.
        assign ovf_d = (as_src[ADDER_WIDTH-1] == b_src[RW-1]) &&
                       (as_d[ADDER_WIDTH-1] != as_src[ADDER_WIDTH-1]);

        // Load the result only for valid slots so bubbles leave it intact
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            ovf_q       <= 1'b0;
          end else if (ce) begin
            out_valid_q <= v_src;
            if (v_src) begin
              sum_q <= {seg_sum[SW], as_d};
              ovf_q <= ovf_d;
            end
          end
        end
      end
    end
  endgenerate

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign ovf       = ovf_q;

endmodule
